// File: rtl/nand_bm_pipe.sv
// nand_bm_pipe: multi-channel N-input NAND with a runtime bubble mask, valid-tagged
// retiming pipeline and a saturating count of delivered samples.
module nand_bm_pipe #(
  parameter int N_IN = 3,
  parameter int CHANNELS = 4,
  parameter logic [N_IN-1:0] INV_MASK_INIT = N_IN'(3'b011),
  parameter int PIPE = 1
) (
  input  logic                     C,
  input  logic                     CLR_N,
  input  logic [CHANNELS*N_IN-1:0] I,
  input  logic                     I_VALID,
  input  logic [N_IN-1:0]          MASK_D,
  input  logic                     MASK_WE,
  input  logic                     CNT_CLR,
  output logic [CHANNELS-1:0]      O,
  output logic                     O_VALID,
  output logic [N_IN-1:0]          MASK_Q,
  output logic [15:0]              SAMPLE_CNT
);
  if (N_IN < 2) begin : g_bad_n_in
    $error("nand_bm_pipe: N_IN must be at least 2");
  end
  logic [N_IN-1:0]                mask_q, mask_d;
  logic [CHANNELS-1:0]            r;
  logic [PIPE-1:0][CHANNELS-1:0]  data_q, data_d;
  logic [PIPE-1:0]                vld_q, vld_d;
  logic [15:0]                    cnt_q, cnt_d;
  // Every stage captures only when its source is valid, so the last stage doubles as the hold register for O.
  always_comb begin
    r = '0;
    for (int k = 0; k < CHANNELS; k++) r[k] = ~&(I[k*N_IN +: N_IN] ^ mask_q);
    mask_d = MASK_WE ? MASK_D : mask_q;
    vld_d = '0;
    data_d = data_q;
    vld_d[0] = I_VALID;
    data_d[0] = I_VALID ? r : data_q[0];
    for (int s = 1; s < PIPE; s++) begin
      vld_d[s] = vld_q[s-1];
      data_d[s] = vld_q[s-1] ? data_q[s-1] : data_q[s];
    end
    cnt_d = CNT_CLR ? 16'd0 : (vld_d[PIPE-1] && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      mask_q <= INV_MASK_INIT;
      data_q <= '1;
      vld_q  <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end
  assign O          = data_q[PIPE-1];
  assign O_VALID    = vld_q[PIPE-1];
  assign MASK_Q     = mask_q;
  assign SAMPLE_CNT = cnt_q;
endmodule

// File: tb/tb_nand_bm_pipe.sv
// tb_nand_bm_pipe: directed checks of nand_bm_pipe at PIPE=1, 3 and 4 sharing one stimulus bus.
module tb_nand_bm_pipe;
  logic        C = 1'b0;
  logic        CLR_N = 1'b1;
  logic [11:0] I = '0;
  logic        I_VALID = 1'b0;
  logic [2:0]  MASK_D = '0;
  logic        MASK_WE = 1'b0;
  logic        CNT_CLR = 1'b0;
  logic [3:0]  o1, o3, o4;
  logic        ov1, ov3, ov4;
  logic [2:0]  m1, m3, m4;
  logic [15:0] c1, c3, c4;
  int          n_chk = 0;
  int          n_fail = 0;

  nand_bm_pipe #(.PIPE(1)) u1 (.C(C), .CLR_N(CLR_N), .I(I), .I_VALID(I_VALID), .MASK_D(MASK_D),
    .MASK_WE(MASK_WE), .CNT_CLR(CNT_CLR), .O(o1), .O_VALID(ov1), .MASK_Q(m1), .SAMPLE_CNT(c1));
  nand_bm_pipe #(.PIPE(3)) u3 (.C(C), .CLR_N(CLR_N), .I(I), .I_VALID(I_VALID), .MASK_D(MASK_D),
    .MASK_WE(MASK_WE), .CNT_CLR(CNT_CLR), .O(o3), .O_VALID(ov3), .MASK_Q(m3), .SAMPLE_CNT(c3));
  nand_bm_pipe #(.PIPE(4)) u4 (.C(C), .CLR_N(CLR_N), .I(I), .I_VALID(I_VALID), .MASK_D(MASK_D),
    .MASK_WE(MASK_WE), .CNT_CLR(CNT_CLR), .O(o4), .O_VALID(ov4), .MASK_Q(m4), .SAMPLE_CNT(c4));

  always #5 C = ~C;

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic do_reset();
    I_VALID = 1'b0;
    MASK_WE = 1'b0;
    CNT_CLR = 1'b0;
    CLR_N = 1'b0;
    #2;
    step();
    CLR_N = 1'b1;
  endtask

  task automatic test_reset();
    step();
    CLR_N = 1'b0;
    #1;
    n_chk++; if (o1 !== 4'b1111) begin n_fail++; $display("FAIL reset_o got %b want 1111", o1); end
    n_chk++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid got %b want 0", ov1); end
    n_chk++; if (m1 !== 3'b011) begin n_fail++; $display("FAIL reset_mask got %b want 011", m1); end
    n_chk++; if (c1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", c1); end
    step();
    CLR_N = 1'b1;
    I = {3'b111, 3'b111, 3'b111, 3'b100};
    I_VALID = 1'b1;
    step();
    I_VALID = 1'b0;
    n_chk++; if (o1 !== 4'b1110) begin n_fail++; $display("FAIL latency_o got %b want 1110", o1); end
    n_chk++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL latency_ovalid got %b want 1", ov1); end
    n_chk++; if (c1 !== 16'd1) begin n_fail++; $display("FAIL latency_cnt got %0d want 1", c1); end
    step();
    n_chk++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %b want 0", ov1); end
    n_chk++; if (o1 !== 4'b1110) begin n_fail++; $display("FAIL latency_hold got %b want 1110", o1); end
  endtask

  task automatic test_truth_table();
    logic [7:0] tt;
    tt = 8'b1110_1111;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      I = {9'b111_111_111, 3'(i)};
      I_VALID = (i < 8);
      step();
      if (i < 2 || i > 9) begin
        n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL tt_ovalid_idle step %0d got %b want 0", i, ov3); end
      end else begin
        n_chk++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL tt_ovalid step %0d got %b want 1", i, ov3); end
        n_chk++; if (o3 !== {3'b111, tt[i-2]}) begin n_fail++; $display("FAIL tt_o code %0d got %b want %b", i-2, o3, {3'b111, tt[i-2]}); end
      end
    end
    I_VALID = 1'b0;
    n_chk++; if (c3 !== 16'd8) begin n_fail++; $display("FAIL tt_cnt got %0d want 8", c3); end
  endtask

  task automatic test_mask_race();
    do_reset();
    I = {3'b111, 3'b111, 3'b111, 3'b100};
    I_VALID = 1'b1;
    MASK_WE = 1'b1;
    MASK_D = 3'b000;
    step();
    MASK_WE = 1'b0;
    n_chk++; if (o1 !== 4'b1110) begin n_fail++; $display("FAIL race_old_mask got %b want 1110", o1); end
    n_chk++; if (m1 !== 3'b000) begin n_fail++; $display("FAIL race_mask_q got %b want 000", m1); end
    step();
    I_VALID = 1'b0;
    n_chk++; if (o1 !== 4'b0001) begin n_fail++; $display("FAIL race_new_mask got %b want 0001", o1); end
    MASK_WE = 1'b1;
    MASK_D = 3'b000;
    step();
    MASK_WE = 1'b0;
    n_chk++; if (m1 !== 3'b000) begin n_fail++; $display("FAIL same_mask_write got %b want 000", m1); end
    n_chk++; if (o1 !== 4'b0001) begin n_fail++; $display("FAIL same_mask_hold got %b want 0001", o1); end
  endtask

  task automatic test_hold_idle();
    do_reset();
    I = {3'b000, 3'b000, 3'b100, 3'b100};
    I_VALID = 1'b1;
    step();
    I_VALID = 1'b0;
    I = 12'hFFF;
    n_chk++; if (o1 !== 4'b1100) begin n_fail++; $display("FAIL hold_first got %b want 1100", o1); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++; if (o1 !== 4'b1100) begin n_fail++; $display("FAIL hold_o cycle %0d got %b want 1100", i, o1); end
      n_chk++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL hold_ovalid cycle %0d got %b want 0", i, ov1); end
      n_chk++; if (c1 !== 16'd1) begin n_fail++; $display("FAIL hold_cnt cycle %0d got %0d want 1", i, c1); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    I = 12'h0;
    I_VALID = 1'b1;
    for (int i = 1; i <= 65540; i++) begin
      step();
      if (i == 65534) begin
        n_chk++; if (c1 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h want fffe", c1); end
      end
    end
    n_chk++; if (c1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", c1); end
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    I_VALID = 1'b0;
    n_chk++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL clr_ovalid got %b want 1", ov1); end
    n_chk++; if (c1 !== 16'd0) begin n_fail++; $display("FAIL clr_priority got %h want 0000", c1); end
    step();
    n_chk++; if (c1 !== 16'd0) begin n_fail++; $display("FAIL clr_after got %h want 0000", c1); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    MASK_WE = 1'b1;
    MASK_D = 3'b000;
    step();
    MASK_WE = 1'b0;
    n_chk++; if (m4 !== 3'b000) begin n_fail++; $display("FAIL mid_mask_set got %b want 000", m4); end
    I = 12'hFFF;
    I_VALID = 1'b1;
    step();
    I_VALID = 1'b0;
    step();
    step();
    CLR_N = 1'b0;
    #1;
    n_chk++; if (o4 !== 4'b1111) begin n_fail++; $display("FAIL mid_o got %b want 1111", o4); end
    n_chk++; if (m4 !== 3'b011) begin n_fail++; $display("FAIL mid_mask got %b want 011", m4); end
    n_chk++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL mid_ovalid got %b want 0", ov4); end
    #7;
    CLR_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse cycle %0d got %b want 0", i, ov4); end
      n_chk++; if (o4 !== 4'b1111) begin n_fail++; $display("FAIL mid_o_ones cycle %0d got %b want 1111", i, o4); end
    end
    n_chk++; if (c4 !== 16'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", c4); end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_mask_race();
    test_hold_idle();
    test_saturation();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
